rec2pol_cordic_param: RTL

- Parametrised iterative CORDIC vectoring engine: converts signed fixed-point rectangular (x,y) to modulus and angle in degrees.
- Successor to the fixed 32-bit, first/fourth-quadrant rec2pol core. Adds:
  - generic width and iteration count
  - full four-quadrant pre-rotation, so angles span (-180,+180]
  - selectable CORDIC-gain compensation with output saturation
  - start/busy/done handshake
- Sits between the sample front-end and the polar post-processing in the signal path.

---
 rtl/rec2pol_pkg.sv | 45 ++++
 rtl/rec2pol_if.sv | 23 ++
 rtl/rec2pol_atan_rom.sv | 23 ++
 rtl/rec2pol_cordic_param.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rec2pol_pkg.sv
// rtl/rec2pol_pkg.sv - shared types and constant functions for the rec2pol CORDIC engine
package rec2pol_pkg;

    typedef enum logic [1:0] {IDLE, PRE, ITER, SCALE} state_t;

    // 1/K = 0.6072529350, kept as a decimal integer so any fraction width can be derived exactly
    localparam logic [127:0] KINV_E10 = 128'd6072529350;
    localparam logic [127:0] PI_E18   = 128'd3141592653589793238;

    function automatic logic [63:0] kinv_q(input int frac);
        logic [127:0] num;
        num = KINV_E10 << frac;
        return 64'(num / 128'd10000000000);
    endfunction

    function automatic logic [63:0] angle_90(input int frac);
        return 64'd90 << frac;
    endfunction

    function automatic logic [63:0] angle_180(input int frac);
        return 64'd180 << frac;
    endfunction

    // atan(2^-i) in degrees, rounded to frac bits; Taylor series in Q.60 radians, then scaled by 180/pi
    function automatic logic [63:0] atan_deg(input int i, input int frac);
        logic [127:0] rad;
        logic [127:0] term;
        logic [127:0] acc;
        if (i == 0) return 64'd45 << frac;
        rad = '0;
        for (int k = 0; k < 32; k++) begin
            int sh;
            sh = i * (2 * k + 1);
            if (sh <= 60) begin
                term = (128'd1 << (60 - sh)) / 128'(2 * k + 1);
                if (k % 2 == 0) rad = rad + term;
                else            rad = rad - term;
            end
        end
        acc = rad * 128'd180 * 128'd1000000000000000000 / PI_E18;
        acc = (acc + (128'd1 << (59 - frac))) >> (60 - frac);
        return acc[63:0];
    endfunction

endpackage

// File: rtl/rec2pol_if.sv
// rtl/rec2pol_if.sv - start/busy/done conversion handshake between front-end and rec2pol core
interface rec2pol_if #(
    parameter int DATA_W = 32
);
    logic                     enable;
    logic                     start;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] y_in;
    logic                     busy;
    logic                     done;
    logic signed [DATA_W-1:0] mod_res;
    logic signed [DATA_W-1:0] angle_res;

    modport master (
        output enable, start, x_in, y_in,
        input  busy, done, mod_res, angle_res
    );

    modport slave (
        input  enable, start, x_in, y_in,
        output busy, done, mod_res, angle_res
    );
endinterface

// File: rtl/rec2pol_atan_rom.sv
// rtl/rec2pol_atan_rom.sv - combinational atan(2^-i) table in degrees, ANG_FRAC fractional bits
module rec2pol_atan_rom #(
    parameter int ANG_FRAC = 22,
    parameter int N_ITER   = 24,
    parameter int OUT_W    = 32
) (
    input  logic [$clog2(N_ITER)-1:0] idx,
    output logic [OUT_W-1:0]          entry
);
    import rec2pol_pkg::*;

    logic [OUT_W-1:0] atan_tab [N_ITER];

    for (genvar g = 0; g < N_ITER; g++) begin : g_tab
        assign atan_tab[g] = OUT_W'(atan_deg(g, ANG_FRAC));
    end

    always_comb begin
        entry = '0;
        if (32'(idx) < N_ITER) entry = atan_tab[idx];
    end

endmodule

// File: rtl/rec2pol_cordic_param.sv
// rtl/rec2pol_cordic_param.sv - iterative four-quadrant CORDIC vectoring: (x,y) to modulus and angle in degrees
module rec2pol_cordic_param #(
    parameter int DATA_W    = 32,
    parameter int FRAC_W    = 16,
    parameter int ANG_FRAC  = 22,
    parameter int N_ITER    = 24,
    parameter int GUARD     = 2,
    parameter int COMP_GAIN = 1
) (
    input  logic     clock,
    input  logic     reset,
    rec2pol_if.slave bus
);
    import rec2pol_pkg::*;

    localparam int W     = DATA_W + GUARD;
    localparam int KW    = FRAC_W + 16;
    localparam int PW    = W + KW + 1;
    localparam int CNT_W = $clog2(N_ITER);

    localparam logic [KW-1:0]            KINV    = KW'(kinv_q(KW));
    localparam logic signed [DATA_W-1:0] Z90     = DATA_W'(angle_90(ANG_FRAC));
    localparam logic signed [DATA_W-1:0] Z180    = DATA_W'(angle_180(ANG_FRAC));
    localparam logic signed [PW-1:0]     MOD_MAX = PW'({1'b0, {(DATA_W-1){1'b1}}});

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [W-1:0]      x_q, x_d, y_q, y_d;
    logic signed [DATA_W-1:0] z_q, z_d, ang_q, ang_d, mod_q, mod_d;
    logic                     axis_q, axis_d, done_q, done_d;
    logic [DATA_W-1:0]        atan_e;
    logic signed [PW-1:0]     prod, mag;

    rec2pol_atan_rom #(
        .ANG_FRAC (ANG_FRAC),
        .N_ITER   (N_ITER),
        .OUT_W    (DATA_W)
    ) u_atan_rom (
        .idx   (cnt_q),
        .entry (atan_e)
    );

    assign prod = PW'(x_q) * PW'($signed({1'b0, KINV}));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        axis_d   = axis_q;
        mod_d    = mod_q;
        ang_d    = ang_q;
        done_d   = 1'b0;
        mag      = '0;
        bus.busy = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = W'(bus.x_in);
                    y_d     = W'(bus.y_in);
                    cnt_d   = '0;
                    state_d = PRE;
                end
            end
            PRE: begin
                state_d = ITER;
                axis_d  = 1'b0;
                z_d     = '0;
                // On the x axis the answer is exact: freeze x, y and z through ITER
                if (y_q == '0) begin
                    axis_d = 1'b1;
                    if (x_q[W-1]) begin
                        x_d = -x_q;
                        z_d = Z180;
                    end
                end else if (x_q[W-1]) begin
                    if (!y_q[W-1]) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = Z90;
                    end else begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = -Z90;
                    end
                end
            end
            ITER: begin
                if (!axis_q) begin
                    if (!y_q[W-1]) begin
                        x_d = x_q + (y_q >>> cnt_q);
                        y_d = y_q - (x_q >>> cnt_q);
                        z_d = z_q + $signed(atan_e);
                    end else begin
                        x_d = x_q - (y_q >>> cnt_q);
                        y_d = y_q + (x_q >>> cnt_q);
                        z_d = z_q - $signed(atan_e);
                    end
                end
                if (cnt_q == CNT_W'(N_ITER - 1)) state_d = SCALE;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            SCALE: begin
                if (axis_q || COMP_GAIN == 0) mag = PW'(x_q);
                else                          mag = prod >>> KW;
                if (mag[PW-1])          mod_d = '0;
                else if (mag > MOD_MAX) mod_d = MOD_MAX[DATA_W-1:0];
                else                    mod_d = mag[DATA_W-1:0];
                ang_d   = z_q;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            axis_q  <= 1'b0;
            mod_q   <= '0;
            ang_q   <= '0;
            done_q  <= 1'b0;
        end else if (bus.enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            axis_q  <= axis_d;
            mod_q   <= mod_d;
            ang_q   <= ang_d;
            done_q  <= done_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.mod_res   = mod_q;
    assign bus.angle_res = ang_q;

endmodule
